// File: rtl/uart_dpram_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_dpram_buf
// Description : Queues bytes received on a UART line in a DEPTH-entry
//               dual-port RAM and, on each debounced key press, dumps the
//               queued bytes (oldest first) back out on the UART transmit
//               line. Drain mode consumes the entries, replay mode keeps
//               them and re-sends them on every press.
// Ports       : clk        - system clock
//               rst        - synchronous reset, active-high
//               key_in     - raw push-button, active-low, bouncy
//               mode       - 0 = drain, 1 = replay (latched at dump start)
//               rs232_rx   - UART receive line, 8N1
//               rs232_tx   - UART transmit line, 8N1, idle high
//               buf_count  - number of valid entries, 0..DEPTH
//               overflow   - sticky: a byte was dropped on a full buffer
//               frame_err  - one-cycle pulse: stop bit sampled low
//               busy       - high while a dump is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_dpram_buf #(
    parameter int CLKS_PER_BIT    = 5208,
    parameter int DEPTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_in,
    input  logic                   mode,
    input  logic                   rs232_rx,
    output logic                   rs232_tx,
    output logic [$clog2(DEPTH):0] buf_count,
    output logic                   overflow,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_BIT_W  = $clog2(CLKS_PER_BIT);
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_HALF_LAST = c_BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_ADDR_W:0]  c_FULL      = (c_ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam logic [2:0] c_D_IDLE = 3'd0;
    localparam logic [2:0] c_D_RD   = 3'd1;
    localparam logic [2:0] c_D_LOAD = 3'd2;
    localparam logic [2:0] c_D_SEND = 3'd3;
    localparam logic [2:0] c_D_NEXT = 3'd4;

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    logic [1:0]         r_rx_sync;
    logic               r_rx_prev;
    logic [1:0]         r_rx_state;
    logic [1:0]         w_rx_next;
    logic [c_BIT_W-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_byte;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               w_rx;

    assign w_rx = r_rx_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= c_RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            // Edge detection (not level) so a line held low after a bad
            // frame does not retrigger.
            c_RX_IDLE:  if (!w_rx && r_rx_prev) w_rx_next = c_RX_START;
            c_RX_START: if (r_rx_cnt == c_HALF_LAST) w_rx_next = w_rx ? c_RX_IDLE : c_RX_DATA;
            c_RX_DATA:  if (r_rx_cnt == c_BIT_LAST && r_rx_bit == 3'd7) w_rx_next = c_RX_STOP;
            c_RX_STOP:  if (r_rx_cnt == c_BIT_LAST) w_rx_next = c_RX_IDLE;
            default:    w_rx_next = c_RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync   <= 2'b11;
            r_rx_prev   <= 1'b1;
            r_rx_cnt    <= '0;
            r_rx_bit    <= 3'd0;
            r_rx_byte   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_sync   <= {r_rx_sync[0], rs232_rx};
            r_rx_prev   <= w_rx;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_rx_state)
                c_RX_START: begin
                    r_rx_cnt <= (r_rx_cnt == c_HALF_LAST) ? '0 : r_rx_cnt + 1'b1;
                end
                c_RX_DATA: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt  <= '0;
                        r_rx_byte <= {w_rx, r_rx_byte[7:1]};
                        r_rx_bit  <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                c_RX_STOP: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt    <= '0;
                        r_rx_valid  <= w_rx;
                        r_frame_err <= !w_rx;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Key debounce and press detection
    // ------------------------------------------------------------------------
    logic [1:0]        r_key_sync;
    logic              r_key_db;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_sync <= 2'b11;
            r_key_db   <= 1'b1;
            r_db_cnt   <= '0;
            r_press    <= 1'b0;
        end else begin
            r_key_sync <= {r_key_sync[0], key_in};
            r_press    <= 1'b0;
            if (r_key_sync[1] == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_db_cnt <= '0;
                r_key_db <= r_key_sync[1];
                r_press  <= !r_key_sync[1];
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Dump FSM
    // ------------------------------------------------------------------------
    logic [2:0]          r_dump_state;
    logic [2:0]          w_dump_next;
    logic                r_mode_l;
    logic [c_ADDR_W:0]   r_n;
    logic [c_ADDR_W:0]   r_i;
    logic [c_ADDR_W:0]   r_count;
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W-1:0] w_rd_addr;
    logic                w_tx_start;
    logic                w_tx_done;
    logic                w_dump_end;
    logic                w_drain_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dump_state <= c_D_IDLE;
        end else begin
            r_dump_state <= w_dump_next;
        end
    end

    always_comb begin
        w_dump_next = r_dump_state;
        w_tx_start  = 1'b0;
        w_dump_end  = 1'b0;
        w_drain_dec = 1'b0;
        case (r_dump_state)
            c_D_IDLE: if (r_press && r_count != '0) w_dump_next = c_D_RD;
            c_D_RD:   w_dump_next = c_D_LOAD;
            c_D_LOAD: begin
                w_tx_start  = 1'b1;
                w_dump_next = c_D_SEND;
            end
            c_D_SEND: if (w_tx_done) w_dump_next = c_D_NEXT;
            c_D_NEXT: begin
                w_drain_dec = !r_mode_l;
                if ((r_i + 1'b1) == r_n) begin
                    w_dump_end  = 1'b1;
                    w_dump_next = c_D_IDLE;
                end else begin
                    w_dump_next = c_D_RD;
                end
            end
            default: w_dump_next = c_D_IDLE;
        endcase
    end

    // Drain advances rd_ptr itself, so the i offset only applies in replay,
    // where rd_ptr stays put and i walks across the retained entries.
    assign w_rd_addr = r_mode_l ? (r_rd_ptr + r_i[c_ADDR_W-1:0]) : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_l <= 1'b0;
            r_n      <= '0;
            r_i      <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (r_dump_state == c_D_IDLE && w_dump_next == c_D_RD) begin
                r_mode_l <= mode;
                r_n      <= r_count;
                r_i      <= '0;
            end
            if (r_dump_state == c_D_NEXT) begin
                r_i <= r_i + 1'b1;
                if (!r_mode_l) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Buffer storage and occupancy
    // ------------------------------------------------------------------------
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;
    logic       r_ovf;
    logic       w_full;
    logic       w_wr_en;

    assign w_full  = (r_count == c_FULL);
    assign w_wr_en = r_rx_valid && !w_full;

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) r_mem[r_wr_ptr] <= r_rx_byte;
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            case ({w_wr_en, w_drain_dec})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a drain completion stays visible.
            if (r_rx_valid && w_full) r_ovf <= 1'b1;
            else if (w_dump_end && !r_mode_l) r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    logic               r_tx;
    logic               r_tx_active;
    logic [8:0]         r_tx_shift;
    logic [3:0]         r_tx_bit;
    logic [c_BIT_W-1:0] r_tx_cnt;

    assign w_tx_done = r_tx_active && (r_tx_cnt == c_BIT_LAST) && (r_tx_bit == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx        <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_shift  <= '1;
            r_tx_bit    <= 4'd0;
            r_tx_cnt    <= '0;
        end else if (w_tx_start) begin
            r_tx        <= 1'b0;
            r_tx_active <= 1'b1;
            r_tx_shift  <= {1'b1, r_rd_data};
            r_tx_bit    <= 4'd0;
            r_tx_cnt    <= '0;
        end else if (r_tx_active) begin
            if (r_tx_cnt == c_BIT_LAST) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_active <= 1'b0;
                    r_tx        <= 1'b1;
                end else begin
                    // Shift register carries data bits then the stop bit.
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_bit   <= r_tx_bit + 1'b1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign rs232_tx  = r_tx;
    assign buf_count = r_count;
    assign overflow  = r_ovf;
    assign frame_err = r_frame_err;
    assign busy      = (r_dump_state != c_D_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_dpram_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_dpram_buf
// Description : Self-checking bench for uart_dpram_buf. A queue model of the
//               buffer predicts what each dump must emit; a line decoder on
//               rs232_tx collects the bytes actually sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_dpram_buf;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int DB    = 50;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_in = 1'b1;
    logic          mode = 1'b0;
    logic          rs232_rx = 1'b1;
    logic          rs232_tx;
    logic [CW-1:0] buf_count;
    logic          overflow;
    logic          frame_err;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ferr_cnt = 0;

    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;

    logic [7:0] mon_q[$];
    int         mon_t[$];
    bit         rst_seen = 1'b0;

    uart_dpram_buf #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(DEPTH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .mode(mode),
        .rs232_rx(rs232_rx),
        .rs232_tx(rs232_tx),
        .buf_count(buf_count),
        .overflow(overflow),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_seen = 1'b1;
    end

    always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

    // Line decoder: samples each bit at its middle; frames cut by reset are dropped.
    initial begin : tx_decoder
        int t0;
        logic [7:0] b;
        logic sb;
        forever begin
            @(negedge clk);
            if (!rst && rs232_tx === 1'b0) begin
                t0 = cyc;
                rst_seen = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = rs232_tx;
                end
                repeat (CPB) @(negedge clk);
                sb = rs232_tx;
                if (!rst_seen) begin
                    checks++;
                    if (sb !== 1'b1) begin
                        errors++;
                        $display("FAIL tx_stop_bit: got %b want 1", sb);
                    end
                    mon_q.push_back(b);
                    mon_t.push_back(t0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_rx(input logic [7:0] b);
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    task automatic uart_send(input logic [7:0] b, input logic sb);
        rs232_rx = 1'b0; tick(CPB);
        for (int k = 0; k < 8; k++) begin rs232_rx = b[k]; tick(CPB); end
        rs232_rx = sb; tick(CPB);
        rs232_rx = 1'b1; tick(4);
    endtask

    task automatic press();
        key_in = 1'b0; tick(70);
        key_in = 1'b1; tick(70);
    endtask

    task automatic wait_idle(output int t_idle, output bit to);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin tick(1); n++; end
        t_idle = cyc;
        to = (n >= 3000);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(3);
        checks++; if (rs232_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", rs232_tx); end
        checks++; if (buf_count !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", buf_count); end
        checks++; if ({overflow, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {overflow, frame_err, busy}); end
        rst = 1'b0; tick(5);
    endtask

    task automatic test_drain_basic();
        logic [7:0] exp[$];
        logic [7:0] pat[3] = '{8'hAA, 8'hF0, 8'h55};
        int t; bit to;
        mode = 1'b0;
        foreach (pat[k]) begin uart_send(pat[k], 1'b1); model_rx(pat[k]); end
        checks++; if (buf_count !== 3) begin errors++; $display("FAIL drain_count_pre: got %0d want 3", buf_count); end
        exp = m_q; m_q.delete(); m_ovf = 1'b0;
        mon_q.delete(); mon_t.delete();
        press();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %b want 1", busy); end
        wait_idle(t, to);
        checks++; if (to) begin errors++; $display("FAIL drain_timeout: got busy %b want 0", busy); end
        checks++; if (mon_q.size() != exp.size()) begin errors++; $display("FAIL drain_nbytes: got %0d want %0d", mon_q.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
            checks++; if (mon_q[k] !== exp[k]) begin errors++; $display("FAIL drain_byte%0d: got %02h want %02h", k, mon_q[k], exp[k]); end
        end
        if (mon_t.size() == 3) begin
            checks++; if (mon_t[1] - mon_t[0] != 163 || mon_t[2] - mon_t[1] != 163) begin errors++; $display("FAIL drain_period: got %0d,%0d want 163", mon_t[1] - mon_t[0], mon_t[2] - mon_t[1]); end
            checks++; if (t - mon_t[2] != 161) begin errors++; $display("FAIL drain_busy_end: got %0d want 161", t - mon_t[2]); end
        end
        checks++; if (buf_count !== 0) begin errors++; $display("FAIL drain_count_post: got %0d want 0", buf_count); end
    endtask

    task automatic test_overflow_wrap();
        logic [7:0] exp[$];
        int t; bit to;
        mode = 1'b0;
        for (int k = 1; k <= 6; k++) begin uart_send(8'(k), 1'b1); model_rx(8'(k)); end
        checks++; if (buf_count !== 4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_full: got count %0d ovf %b want 4 1", buf_count, overflow); end
        for (int r = 0; r < 2; r++) begin
            exp = m_q; m_q.delete(); m_ovf = 1'b0;
            mon_q.delete();
            press(); wait_idle(t, to);
            checks++; if (to || mon_q.size() != exp.size()) begin errors++; $display("FAIL ovf_nbytes%0d: got %0d want %0d", r, mon_q.size(), exp.size()); end
            for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
                checks++; if (mon_q[k] !== exp[k]) begin errors++; $display("FAIL ovf_byte%0d_%0d: got %02h want %02h", r, k, mon_q[k], exp[k]); end
            end
            checks++; if (overflow !== 1'b0 || buf_count !== 0) begin errors++; $display("FAIL ovf_clear%0d: got ovf %b count %0d want 0 0", r, overflow, buf_count); end
            if (r == 0) begin uart_send(8'h07, 1'b1); model_rx(8'h07); end
        end
    endtask

    task automatic test_replay();
        int t; bit to;
        mode = 1'b1;
        uart_send(8'h12, 1'b1); model_rx(8'h12);
        uart_send(8'h34, 1'b1); model_rx(8'h34);
        mon_q.delete();
        for (int r = 0; r < 2; r++) begin
            press();
            checks++; if (busy !== 1'b1 || buf_count !== 2) begin errors++; $display("FAIL replay_mid%0d: got busy %b count %0d want 1 2", r, busy, buf_count); end
            wait_idle(t, to);
            checks++; if (to) begin errors++; $display("FAIL replay_timeout%0d: got busy %b want 0", r, busy); end
        end
        checks++; if (mon_q.size() != 4) begin errors++; $display("FAIL replay_nbytes: got %0d want 4", mon_q.size()); end
        for (int k = 0; k < 4 && k < mon_q.size(); k++) begin
            checks++; if (mon_q[k] !== m_q[k % 2]) begin errors++; $display("FAIL replay_byte%0d: got %02h want %02h", k, mon_q[k], m_q[k % 2]); end
        end
        checks++; if (buf_count !== 2) begin errors++; $display("FAIL replay_count: got %0d want 2", buf_count); end
    endtask

    task automatic test_bounce();
        int t; bit to;
        mode = 1'b1;
        mon_q.delete();
        for (int k = 0; k < 20; k++) begin key_in = ~key_in; tick($urandom_range(1, 40)); end
        press(); wait_idle(t, to);
        tick(200);
        checks++; if (to || mon_q.size() != m_q.size()) begin errors++; $display("FAIL bounce_ndumps: got %0d bytes want %0d", mon_q.size(), m_q.size()); end
    endtask

    task automatic test_press_during_dump();
        int t; bit to;
        mode = 1'b1;
        mon_q.delete();
        press();
        mode = 1'b0;
        press();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL during_busy: got %b want 1", busy); end
        wait_idle(t, to);
        tick(400);
        checks++; if (to || busy !== 1'b0 || mon_q.size() != m_q.size()) begin errors++; $display("FAIL during_ignored: got %0d bytes want %0d", mon_q.size(), m_q.size()); end
        checks++; if (buf_count !== CW'(m_q.size())) begin errors++; $display("FAIL during_count: got %0d want %0d", buf_count, m_q.size()); end
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        logic [7:0] b;
        int t; bit to;
        for (int it = 0; it < 4; it++) begin
            for (int j = $urandom_range(1, 6); j > 0; j--) begin
                b = 8'($urandom); uart_send(b, 1'b1); model_rx(b);
            end
            checks++; if (buf_count !== CW'(m_q.size()) || overflow !== m_ovf) begin errors++; $display("FAIL rand_pre%0d: got count %0d ovf %b want %0d %b", it, buf_count, overflow, m_q.size(), m_ovf); end
            mode = (it == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            exp = m_q;
            if (!mode) begin m_q.delete(); m_ovf = 1'b0; end
            mon_q.delete();
            press(); wait_idle(t, to);
            checks++; if (to || mon_q.size() != exp.size()) begin errors++; $display("FAIL rand_nbytes%0d: got %0d want %0d", it, mon_q.size(), exp.size()); end
            for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
                checks++; if (mon_q[k] !== exp[k]) begin errors++; $display("FAIL rand_byte%0d_%0d: got %02h want %02h", it, k, mon_q[k], exp[k]); end
            end
            checks++; if (buf_count !== CW'(m_q.size()) || overflow !== m_ovf) begin errors++; $display("FAIL rand_post%0d: got count %0d ovf %b want %0d %b", it, buf_count, overflow, m_q.size(), m_ovf); end
        end
    endtask

    task automatic test_empty_press();
        bit seen_busy = 1'b0;
        bit seen_low = 1'b0;
        fork
            press();
            for (int k = 0; k < 150; k++) begin
                @(negedge clk);
                if (busy !== 1'b0) seen_busy = 1'b1;
                if (rs232_tx !== 1'b1) seen_low = 1'b1;
            end
        join
        checks++; if (seen_busy) begin errors++; $display("FAIL empty_busy: got 1 want 0"); end
        checks++; if (seen_low) begin errors++; $display("FAIL empty_tx: got low want high"); end
    endtask

    task automatic test_rx_errors();
        int f0 = ferr_cnt;
        uart_send(8'h5A, 1'b0); tick(20);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
        checks++; if (buf_count !== CW'(m_q.size())) begin errors++; $display("FAIL ferr_count: got %0d want %0d", buf_count, m_q.size()); end
        rs232_rx = 1'b0; tick(4); rs232_rx = 1'b1; tick(200);
        checks++; if (buf_count !== CW'(m_q.size()) || ferr_cnt - f0 != 1) begin errors++; $display("FAIL glitch: got count %0d want %0d", buf_count, m_q.size()); end
        uart_send(8'hC3, 1'b1); model_rx(8'hC3);
        checks++; if (buf_count !== CW'(m_q.size())) begin errors++; $display("FAIL post_glitch_rx: got %0d want %0d", buf_count, m_q.size()); end
    endtask

    task automatic test_concurrent();
        logic [7:0] exp[$];
        logic [7:0] b;
        int t, nw; bit to, to_mon;
        mode = 1'b0;
        while (m_q.size() < 3) begin b = 8'($urandom); uart_send(b, 1'b1); model_rx(b); end
        exp = m_q; m_q.delete(); m_ovf = 1'b0;
        mon_q.delete(); to_mon = 1'b0; nw = 0;
        fork
            press();
            begin
                while (mon_q.size() < 1 && nw < 1000) begin tick(1); nw++; end
                if (nw >= 1000) to_mon = 1'b1;
                else uart_send(8'h99, 1'b1);
            end
        join
        model_rx(8'h99);
        wait_idle(t, to);
        checks++; if (to || to_mon || mon_q.size() != 3) begin errors++; $display("FAIL conc_nbytes: got %0d want 3", mon_q.size()); end
        for (int k = 0; k < 3 && k < mon_q.size(); k++) begin
            checks++; if (mon_q[k] !== exp[k]) begin errors++; $display("FAIL conc_byte%0d: got %02h want %02h", k, mon_q[k], exp[k]); end
        end
        checks++; if (buf_count !== 1) begin errors++; $display("FAIL conc_count: got %0d want 1", buf_count); end
        mon_q.delete(); m_q.delete();
        press(); wait_idle(t, to);
        checks++; if (to || mon_q.size() != 1 || mon_q[0] !== 8'h99) begin errors++; $display("FAIL conc_second: got %0d bytes want one 99", mon_q.size()); end
    endtask

    task automatic test_reset_mid_dump();
        logic [7:0] b;
        mode = 1'b0;
        for (int k = 0; k < 2; k++) begin b = 8'($urandom); uart_send(b, 1'b1); model_rx(b); end
        mon_q.delete();
        press();
        checks++; if (busy !== 1'b1 || rs232_tx === 1'bx) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        rst = 1'b1; tick(1);
        checks++; if (rs232_tx !== 1'b1 || buf_count !== 0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got tx %b count %0d busy %b want 1 0 0", rs232_tx, buf_count, busy);
        end
        rst = 1'b0; m_q.delete(); m_ovf = 1'b0;
        tick(300);
        checks++; if (mon_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_resume: got %0d bytes want 0", mon_q.size()); end
    endtask

    initial begin
        test_reset();
        test_drain_basic();
        test_overflow_wrap();
        test_replay();
        test_bounce();
        test_press_during_dump();
        test_random();
        test_empty_press();
        test_rx_errors();
        test_concurrent();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
